// File: rtl/gemm_uop_seq_if.sv
// Index-tuple stream from the GEMM micro-op sequencer to the MAC datapath.
// valid/ready handshake: a tuple transfers on a cycle where out_valid and out_ready are both high.
interface gemm_uop_seq_if #(
  parameter int ACC_IDX_WIDTH = 11,
  parameter int INP_IDX_WIDTH = 11,
  parameter int WGT_IDX_WIDTH = 10
);
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_IDX_WIDTH-1:0] out_acc_idx;
  logic [INP_IDX_WIDTH-1:0] out_inp_idx;
  logic [WGT_IDX_WIDTH-1:0] out_wgt_idx;
  logic                     out_reset;
  logic                     out_last;

  modport master (
    output out_valid, out_acc_idx, out_inp_idx, out_wgt_idx, out_reset, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_acc_idx, out_inp_idx, out_wgt_idx, out_reset, out_last,
    output out_ready
  );
endinterface

// File: rtl/gemm_uop_seq.sv
// GEMM micro-op sequencer: decodes one GEMM insn, walks iter_out x iter_in x [uop_bgn,uop_end),
// reads the uop memory, adds loop-scaled offsets and streams (acc,inp,wgt) tuples through a
// 2-entry output buffer. ap_ctrl_hs-style start/done towards the core FSM.
module gemm_uop_seq #(
  parameter int         INS_WIDTH     = 128,
  parameter int         UOP_WIDTH     = 32,
  parameter int         UPC_WIDTH     = 13,
  parameter int         ITER_WIDTH    = 14,
  parameter int         ACC_IDX_WIDTH = 11,
  parameter int         INP_IDX_WIDTH = 11,
  parameter int         WGT_IDX_WIDTH = 10,
  parameter logic [2:0] GEMM_OPCODE   = 3'd2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_idle,
  output logic                 ap_ready,
  output logic                 ap_done,
  input  logic [INS_WIDTH-1:0] insn,
  output logic [UPC_WIDTH-1:0] upc,
  output logic                 uop_ce,
  input  logic [UOP_WIDTH-1:0] uop,
  gemm_uop_seq_if.master       idx_bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [ACC_IDX_WIDTH-1:0] acc;
    logic [INP_IDX_WIDTH-1:0] inp;
    logic [WGT_IDX_WIDTH-1:0] wgt;
    logic                     rst;
    logic                     last;
  } tuple_t;

  // Instruction fields (field map is fixed by the ISA).
  logic [2:0]               f_opcode;
  logic                     f_reset;
  logic [UPC_WIDTH-1:0]     f_bgn;
  logic [ITER_WIDTH-1:0]    f_end, f_iter_out, f_iter_in;
  logic [ACC_IDX_WIDTH-1:0] f_dst_out, f_dst_in;
  logic [INP_IDX_WIDTH-1:0] f_src_out, f_src_in;
  logic [WGT_IDX_WIDTH-1:0] f_wgt_out, f_wgt_in;
  logic                     unused_insn_bits;

  assign f_opcode         = insn[2:0];
  assign f_reset          = insn[7];
  assign f_bgn            = insn[20:8];
  assign f_end            = insn[34:21];
  assign f_iter_out       = insn[48:35];
  assign f_iter_in        = insn[62:49];
  assign f_dst_out        = insn[73:63];
  assign f_dst_in         = insn[84:74];
  assign f_src_out        = insn[95:85];
  assign f_src_in         = insn[106:96];
  assign f_wgt_out        = insn[116:107];
  assign f_wgt_in         = insn[126:117];
  assign unused_insn_bits = ^{insn[6:3], insn[127]};

  logic [1:0]               state;
  logic                     reset_q;
  logic [UPC_WIDTH-1:0]     bgn_q;
  logic [ITER_WIDTH-1:0]    end_q, iter_out_q, iter_in_q;
  logic [ACC_IDX_WIDTH-1:0] dst_out_q, dst_in_q, acc_o, acc_i, acc_d;
  logic [INP_IDX_WIDTH-1:0] src_out_q, src_in_q, inp_o, inp_i, inp_d;
  logic [WGT_IDX_WIDTH-1:0] wgt_out_q, wgt_in_q, wgt_o, wgt_i, wgt_d;
  // upc_cnt is one bit wider than the address so uop_end can sit past the top of uop memory.
  logic [ITER_WIDTH-1:0]    upc_cnt, i_in, i_out;
  logic                     last_uop, last_in, last_out, last_all, last_d;
  logic                     zero_work, pend, pop;
  logic [1:0]               occ, fill;
  tuple_t                   buf0, buf1, new_t;

  assign zero_work = (f_opcode != GEMM_OPCODE) || (f_iter_out == '0) || (f_iter_in == '0) ||
                     (f_end <= ITER_WIDTH'(f_bgn));

  assign last_uop = (upc_cnt == end_q - ITER_WIDTH'(1));
  assign last_in  = (i_in == iter_in_q - ITER_WIDTH'(1));
  assign last_out = (i_out == iter_out_q - ITER_WIDTH'(1));
  assign last_all = last_uop && last_in && last_out;

  // Entries held after this cycle's pop plus the read landing at this edge; a new read only
  // issues if it is guaranteed a slot two edges from now, so nothing is ever dropped.
  assign pop    = idx_bus.out_valid && idx_bus.out_ready;
  assign fill   = occ - {1'b0, pop} + {1'b0, pend};
  assign uop_ce = (state == S_RUN) && (fill < 2'd2);
  assign upc    = upc_cnt[UPC_WIDTH-1:0];

  assign ap_idle  = (state == S_IDLE);
  assign ap_ready = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);

  // Control FSM plus the loop nest; offsets are running sums stepped alongside the counters.
  // NOTE: state registers use non-blocking assignments so every always_ff sees pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      reset_q    <= 1'b0;
      bgn_q      <= '0;
      end_q      <= '0;
      iter_out_q <= '0;
      iter_in_q  <= '0;
      dst_out_q  <= '0;
      dst_in_q   <= '0;
      src_out_q  <= '0;
      src_in_q   <= '0;
      wgt_out_q  <= '0;
      wgt_in_q   <= '0;
      upc_cnt    <= '0;
      i_in       <= '0;
      i_out      <= '0;
      acc_o      <= '0;
      acc_i      <= '0;
      inp_o      <= '0;
      inp_i      <= '0;
      wgt_o      <= '0;
      wgt_i      <= '0;
    end else begin
      case (state)
        S_IDLE: if (ap_start) begin
          reset_q    <= f_reset;
          bgn_q      <= f_bgn;
          end_q      <= f_end;
          iter_out_q <= f_iter_out;
          iter_in_q  <= f_iter_in;
          dst_out_q  <= f_dst_out;
          dst_in_q   <= f_dst_in;
          src_out_q  <= f_src_out;
          src_in_q   <= f_src_in;
          wgt_out_q  <= f_wgt_out;
          wgt_in_q   <= f_wgt_in;
          upc_cnt    <= ITER_WIDTH'(f_bgn);
          i_in       <= '0;
          i_out      <= '0;
          acc_o      <= '0;
          acc_i      <= '0;
          inp_o      <= '0;
          inp_i      <= '0;
          wgt_o      <= '0;
          wgt_i      <= '0;
          state      <= zero_work ? S_DONE : S_RUN;
        end
        S_RUN: if (uop_ce) begin
          if (!last_uop) begin
            upc_cnt <= upc_cnt + ITER_WIDTH'(1);
          end else begin
            upc_cnt <= ITER_WIDTH'(bgn_q);
            if (!last_in) begin
              i_in  <= i_in + ITER_WIDTH'(1);
              acc_i <= acc_i + dst_in_q;
              inp_i <= inp_i + src_in_q;
              wgt_i <= wgt_i + wgt_in_q;
            end else begin
              i_in <= '0;
              if (!last_out) begin
                i_out <= i_out + ITER_WIDTH'(1);
                acc_o <= acc_o + dst_out_q;
                acc_i <= acc_o + dst_out_q;
                inp_o <= inp_o + src_out_q;
                inp_i <= inp_o + src_out_q;
                wgt_o <= wgt_o + wgt_out_q;
                wgt_i <= wgt_o + wgt_out_q;
              end else begin
                state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: if (pop && buf0.last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Loop metadata travels one cycle behind the uop read so it meets the returning uop data.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      pend   <= 1'b0;
      acc_d  <= '0;
      inp_d  <= '0;
      wgt_d  <= '0;
      last_d <= 1'b0;
    end else begin
      pend <= uop_ce;
      if (uop_ce) begin
        acc_d  <= acc_i;
        inp_d  <= inp_i;
        wgt_d  <= wgt_i;
        last_d <= last_all;
      end
    end
  end

  // Tuple formed from the returning uop and its delayed offsets (modulo index width).
  // NOTE: every field gets a default first so this block can never infer a latch.
  always_comb begin
    new_t      = '0;
    new_t.acc  = uop[ACC_IDX_WIDTH-1:0] + acc_d;
    new_t.inp  = uop[ACC_IDX_WIDTH+INP_IDX_WIDTH-1:ACC_IDX_WIDTH] + inp_d;
    new_t.wgt  = uop[UOP_WIDTH-1:ACC_IDX_WIDTH+INP_IDX_WIDTH] + wgt_d;
    new_t.rst  = reset_q;
    new_t.last = last_d;
  end

  // Two-entry output buffer; buf0 is the head and only changes on a pop or when empty.
  // NOTE: the buffer payload is reset as well so every output reads 0 straight out of reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({pend, pop})
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) buf0 <= new_t;
          else             buf1 <= new_t;
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= new_t;
          end else begin
            buf0 <= buf1;
            buf1 <= new_t;
          end
        end
        default: ;
      endcase
    end
  end

  assign idx_bus.out_valid   = (occ != 2'd0);
  assign idx_bus.out_acc_idx = buf0.acc;
  assign idx_bus.out_inp_idx = buf0.inp;
  assign idx_bus.out_wgt_idx = buf0.wgt;
  assign idx_bus.out_reset   = buf0.rst;
  assign idx_bus.out_last    = buf0.last;

endmodule
